solitaire_dealer: RTL

//  Parametrised deal engine: builds an ordered deck, shuffles it in place (Fisher-Yates, LFSR-driven),

---
 rtl/solitaire_pkg.sv | 33 +++
 rtl/deal_lfsr.sv | 22 ++
 rtl/solitaire_dealer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/solitaire_pkg.sv
// solitaire_pkg: card field layout, suit codes, destination encoding, FSM states, LFSR helpers
package solitaire_pkg;

    localparam int CARD_W  = 7;
    localparam int RANK_HI = 6;
    localparam int RANK_LO = 3;
    localparam int SUIT_HI = 2;
    localparam int SUIT_LO = 1;
    localparam int UP_BIT  = 0;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {HEARTS = 2'd0, SPADES = 2'd1, DIAMONDS = 2'd2, CLUBS = 2'd3} suit_e;

    typedef enum logic [2:0] {S_IDLE, S_BUILD, S_SHUFFLE, S_DEAL, S_STOCK, S_DONE} state_e;

    // The stock pile sits one past the last tableau pile
    function automatic int stock_dest(input int num_piles);
        return num_piles;
    endfunction

    // Smallest (power of two) - 1 that covers v, used to bound shuffle candidates
    function automatic logic [15:0] pow2_mask(input logic [15:0] v);
        logic [15:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/deal_lfsr.sv
// deal_lfsr: 16-bit right-shifting Galois LFSR with load/step; a zero seed becomes 16'h0001
module deal_lfsr
    import solitaire_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // Load wins over step so a fresh deal always starts from the seed
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            value <= 16'h0001;
        else if (load)
            value <= seed == 16'h0000 ? 16'h0001 : seed;
        else if (step)
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);

endmodule

// File: rtl/solitaire_dealer.sv
// solitaire_dealer: builds, Fisher-Yates shuffles and streams a deck to tableau/stock piles (option DEALER_SEED_PORT_EN adds seed_in)
module solitaire_dealer
    import solitaire_pkg::*;
#(
    parameter int          CARD_SIZE = CARD_W,
    parameter int          DECK_SIZE = 52,
    parameter int          NUM_SUITS = 4,
    parameter int          NUM_PILES = 7,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst_n,
`ifdef DEALER_SEED_PORT_EN
    input  logic [15:0]                      seed_in,
`endif
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             card_valid,
    input  logic                             card_ready,
    output logic [CARD_SIZE-1:0]             card_data,
    output logic [$clog2(NUM_PILES+1)-1:0]   card_dest,
    output logic [$clog2(DECK_SIZE)-1:0]     card_pos
);

    localparam int DW = $clog2(NUM_PILES + 1);
    localparam int PW = $clog2(DECK_SIZE);
    localparam int IW = $clog2(DECK_SIZE);
    localparam int CW = $clog2(DECK_SIZE + 1);
    localparam logic [DW-1:0] STOCK_DEST = DW'(stock_dest(NUM_PILES));

    state_e               state;
    logic [CARD_SIZE-1:0] deck [DECK_SIZE];
    logic [IW-1:0]        si;
    logic [IW-1:0]        sj;
    logic [CW-1:0]        cidx;
    logic [DW-1:0]        cr;
    logic [DW-1:0]        cp;
    logic [PW-1:0]        csp;
    logic [3:0]           brank;
    logic [1:0]           bsuit;
    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_seed;
    logic [15:0]          j16;
    logic                 start_ok;
    logic                 hit;
    logic                 take;
    logic                 deal_up;

`ifdef DEALER_SEED_PORT_EN
    assign lfsr_seed = seed_in;
`else
    assign lfsr_seed = SEED;
`endif

    deal_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .step  (state == S_SHUFFLE),
        .seed  (lfsr_seed),
        .value (lfsr_q)
    );

    // Shuffle candidate, stream advance and top-card detection
    always_comb begin
        start_ok = start && (state == S_IDLE || state == S_DONE);
        j16      = lfsr_q & pow2_mask(16'(si));
        sj       = j16[IW-1:0];
        hit      = j16 <= 16'(si);
        take     = (state == S_DEAL || state == S_STOCK) && (!card_valid || card_ready);
        deal_up  = state == S_DEAL && cp == cr;
    end

    // Deal FSM: deck storage, shuffle swaps and the registered card stream
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            card_valid <= 1'b0;
            card_data  <= '0;
            card_dest  <= '0;
            card_pos   <= '0;
            si         <= '0;
            cidx       <= '0;
            cr         <= '0;
            cp         <= '0;
            csp        <= '0;
            brank      <= 4'd1;
            bsuit      <= 2'd0;
            for (int k = 0; k < DECK_SIZE; k++) deck[k] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE:
                    if (start) begin
                        state <= S_BUILD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        cidx  <= '0;
                        brank <= 4'd1;
                        bsuit <= HEARTS;
                    end
                S_BUILD: begin
                    deck[cidx[IW-1:0]] <= {brank, bsuit, 1'b0};
                    bsuit <= bsuit == 2'(NUM_SUITS - 1) ? 2'd0 : bsuit + 2'd1;
                    brank <= bsuit == 2'(NUM_SUITS - 1) ? brank + 4'd1 : brank;
                    cidx  <= cidx == CW'(DECK_SIZE - 1) ? '0 : cidx + 1'b1;
                    if (cidx == CW'(DECK_SIZE - 1)) begin
                        state <= S_SHUFFLE;
                        si    <= IW'(DECK_SIZE - 1);
                    end
                end
                S_SHUFFLE:
                    if (hit) begin
                        deck[si] <= deck[sj];
                        deck[sj] <= deck[si];
                        si       <= si - 1'b1;
                        if (si == IW'(1)) begin
                            state <= S_DEAL;
                            cidx  <= '0;
                            cr    <= '0;
                            cp    <= '0;
                            csp   <= '0;
                        end
                    end
                S_DEAL, S_STOCK:
                    if (take) begin
                        if (cidx == CW'(DECK_SIZE)) begin
                            card_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            card_valid <= 1'b1;
                            card_data  <= deck[cidx[IW-1:0]] | CARD_SIZE'(deal_up);
                            card_dest  <= state == S_DEAL ? cp : STOCK_DEST;
                            card_pos   <= state == S_DEAL ? PW'(cr) : csp;
                            cidx       <= cidx + 1'b1;
                            if (state == S_STOCK)
                                csp <= csp + 1'b1;
                            else if (cp == DW'(NUM_PILES - 1)) begin
                                cr <= cr + 1'b1;
                                cp <= cr + 1'b1;
                                if (cr == DW'(NUM_PILES - 1)) state <= S_STOCK;
                            end else
                                cp <= cp + 1'b1;
                        end
                    end
                default: state <= S_IDLE;
            endcase
        end

endmodule
